// File: rtl/cycle_stim_pkg.sv
// Shared types and constants for the cycle-computer stimulus sequencer.
package cycle_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CH_FORK  = 0;
    localparam int unsigned CH_CRANK = 1;
    localparam int unsigned CH_MODE  = 2;
    localparam int unsigned CH_TRIP  = 3;

    localparam int unsigned PER_W_DEF = 16;
    typedef logic [PER_W_DEF-1:0] period_t;

endpackage

// File: rtl/stim_pulse_chan.sv
// One pulse channel: phase counter, period compare and registered pulse.
// period_i is the period that applies to the coming cycle; the pulse is
// registered from the next phase value so pulse_o lines up with phase.
module stim_pulse_chan #(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic             pulse_o
);

    logic [PER_W-1:0] phase_q, phase_d;
    logic             pulse_q, pulse_d;
    logic             wrap;

    // Next phase and pulse; idle or clear restarts the phase at 0.
    always_comb begin
        phase_d = '0;
        pulse_d = 1'b0;
        wrap    = (period_i != '0) && (phase_q == period_i - 1'b1);
        if (enable_i) begin
            if (!clear_i && !wrap) begin
                phase_d = phase_q + 1'b1;
            end
            pulse_d = (period_i != '0) && (phase_d == period_i - 1'b1);
        end
    end

    // Phase and pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cycle_sensor_stim_seq.sv
// Scenario sequencer for fork/crank/mode/trip pulse trains.
// Optional macro STIM_SEQ_LOOP_EN: wrap to step 0 after the last step
// instead of entering DONE.
module cycle_sensor_stim_seq
    import cycle_stim_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PER_W       = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STEP_CYCLES = 1000
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_step,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [PER_W-1:0]           cfg_period,
    input  logic [$clog2(DEPTH):0]     cfg_num_steps,
    input  logic                       start,
    input  logic                       stop,
    output logic [NUM_CH-1:0]          pulse_out,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SI_W = $clog2(DEPTH);
    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned SC_W = $clog2(STEP_CYCLES);

    logic [PER_W-1:0] table_q [DEPTH][NUM_CH];

    state_t          state_q, state_d;
    logic [SI_W-1:0] step_idx_q, step_idx_d;
    logic [SC_W-1:0] step_cnt_q, step_cnt_d;
    logic [SI_W:0]   num_steps_q, num_steps_d;
    logic            step_term, last_step;
    logic            chan_en, chan_clr;

    // Scenario table; writable only outside RUN, out-of-range channels ignored.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    table_q[s][c] <= '0;
                end
            end
        end else if (cfg_we && state_q != RUN) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (cfg_ch == CH_W'(c)) begin
                    table_q[cfg_step][c] <= cfg_period;
                end
            end
        end
    end

    // Next-state, step counter and step index; stop outranks start and advance.
    always_comb begin
        state_d     = state_q;
        step_idx_d  = step_idx_q;
        step_cnt_d  = step_cnt_q;
        num_steps_d = num_steps_q;
        step_term   = (state_q == RUN) && (step_cnt_q == SC_W'(STEP_CYCLES - 1));
        last_step   = (({1'b0, step_idx_q} + 1'b1) == num_steps_q);
        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    num_steps_d = cfg_num_steps;
                    step_idx_d  = '0;
                    step_cnt_d  = '0;
                    state_d     = (cfg_num_steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d    = IDLE;
                    step_cnt_d = '0;
                end else if (step_term) begin
                    step_cnt_d = '0;
                    if (last_step) begin
`ifdef STIM_SEQ_LOOP_EN
                        step_idx_d = '0;
`else
                        state_d = DONE;
`endif
                    end else begin
                        step_idx_d = step_idx_q + 1'b1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        chan_en  = (state_d == RUN);
        chan_clr = (state_q != RUN) || step_term;
    end

    // Sequencer state registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            step_idx_q  <= '0;
            step_cnt_q  <= '0;
            num_steps_q <= '0;
        end else begin
            state_q     <= state_d;
            step_idx_q  <= step_idx_d;
            step_cnt_q  <= step_cnt_d;
            num_steps_q <= num_steps_d;
        end
    end

    // Channels read the period of the step that the coming cycle belongs to.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        stim_pulse_chan #(.PER_W(PER_W)) u_chan (
            .clk_i    (HCLK),
            .rst_i    (HRESET),
            .period_i (table_q[step_idx_d][c]),
            .clear_i  (chan_clr),
            .enable_i (chan_en),
            .pulse_o  (pulse_out[c])
        );
    end

    assign step_idx = step_idx_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_cycle_sensor_stim_seq.sv
// Directed bench for cycle_sensor_stim_seq with STEP_CYCLES=20.
module tb_cycle_sensor_stim_seq;
    import cycle_stim_pkg::*;

    localparam int NUM_CH = 4;
    localparam int PER_W  = 16;
    localparam int DEPTH  = 16;
    localparam int SC     = 20;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_step = '0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic [4:0]  cfg_num_steps = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  pulse_out;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int tbl [DEPTH][NUM_CH];
    int cnt;

    always #5 HCLK = ~HCLK;

    cycle_sensor_stim_seq #(
        .NUM_CH      (NUM_CH),
        .PER_W       (PER_W),
        .DEPTH       (DEPTH),
        .STEP_CYCLES (SC)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .cfg_we        (cfg_we),
        .cfg_step      (cfg_step),
        .cfg_ch        (cfg_ch),
        .cfg_period    (cfg_period),
        .cfg_num_steps (cfg_num_steps),
        .start         (start),
        .stop          (stop),
        .pulse_out     (pulse_out),
        .step_idx      (step_idx),
        .busy          (busy),
        .done          (done)
    );

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int s, input int c, input int p);
        cfg_we     = 1'b1;
        cfg_step   = s[3:0];
        cfg_ch     = c[1:0];
        cfg_period = p[15:0];
        tick();
        cfg_we = 1'b0;
        tbl[s][c] = p;
    endtask

    // Cycle k of a run (1-based): channel fires when its in-step cycle number is a multiple of P.
    function automatic logic [3:0] model(input int k);
        logic [3:0] m;
        int s, j, p;
        s = (k - 1) / SC;
        j = (k - 1) % SC + 1;
        m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            p = tbl[s][c];
            m[c] = (p != 0) && (j % p == 0);
        end
        return m;
    endfunction

    task automatic begin_run(input int n);
        cfg_num_steps = n[4:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic play(input string tag, input int ncyc, input int stop_at,
                        input int wr_at, input int cch, output int pcnt);
        pcnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            chk($sformatf("%s.pulse@%0d", tag, k), 32'(pulse_out), 32'(model(k)));
            chk($sformatf("%s.busy@%0d", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s.step@%0d", tag, k), 32'(step_idx), 32'((k - 1) / SC));
            if (pulse_out[cch]) pcnt++;
            if (k == wr_at) begin
                cfg_we = 1'b1; cfg_step = 4'd0; cfg_ch = 2'd0; cfg_period = 16'd2;
            end
            if (k == stop_at) stop = 1'b1;
            tick();
            cfg_we = 1'b0;
            stop   = 1'b0;
            if (k == stop_at) break;
        end
    endtask

    task automatic expect_end(input string tag);
`ifndef STIM_SEQ_LOOP_EN
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".pulse"}, 32'(pulse_out), 32'd0);
`else
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".wrap"}, 32'(step_idx), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk({tag, ".stopbusy"}, 32'(busy), 32'd0);
        chk({tag, ".stoppulse"}, 32'(pulse_out), 32'd0);
`endif
    endtask

    initial begin
        for (int s = 0; s < DEPTH; s++)
            for (int c = 0; c < NUM_CH; c++) tbl[s][c] = 0;

        tick();
        tick();
        chk("rst.pulse", 32'(pulse_out), 32'd0);
        chk("rst.step", 32'(step_idx), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        HRESET = 1'b0;
        tick();

        // Single step, fork P=5: pulses at cycles 5,10,15,20.
        wr(0, CH_FORK, 5);
        begin_run(1);
        play("A", 20, 0, 0, CH_FORK, cnt);
        chk("A.count", 32'(cnt), 32'd4);
        expect_end("A");

        // Two steps: crank 4 then 7, mode 25 then 3 (no carry), trip 1 then 0.
        wr(0, CH_CRANK, 4);
        wr(1, CH_CRANK, 7);
        wr(0, CH_MODE, 25);
        wr(1, CH_MODE, 3);
        wr(0, CH_TRIP, 1);
        begin_run(2);
        play("B", 40, 0, 0, CH_CRANK, cnt);
        chk("B.count", 32'(cnt), 32'd7);
        expect_end("B");

        // Stop at cycle 7 with a write attempted during RUN at cycle 3.
        begin_run(2);
        play("C", 7, 7, 3, CH_FORK, cnt);
        chk("C.count", 32'(cnt), 32'd1);
        chk("C.busy8", 32'(busy), 32'd0);
        chk("C.pulse8", 32'(pulse_out), 32'd0);
        chk("C.done8", 32'(done), 32'd0);
        begin_run(2);
        play("C2", 40, 0, 0, CH_FORK, cnt);
        chk("C2.count", 32'(cnt), 32'd4);
        expect_end("C2");

        // Zero steps: straight to DONE without pulses.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("D.idlebusy", 32'(busy), 32'd0);
        chk("D.idledone", 32'(done), 32'd0);
        begin_run(0);
        chk("D.done", 32'(done), 32'd1);
        chk("D.busy", 32'(busy), 32'd0);
        chk("D.pulse", 32'(pulse_out), 32'd0);
        tick();
        chk("D.pulse2", 32'(pulse_out), 32'd0);
        chk("D.done2", 32'(done), 32'd1);

        // Asynchronous reset in RUN, then confirm the table was cleared.
        begin_run(2);
        play("E", 5, 0, 0, CH_TRIP, cnt);
        chk("E.prepulse", 32'(pulse_out), 32'(model(6)));
        #2;
        HRESET = 1'b1;
        #1;
        chk("E.rstbusy", 32'(busy), 32'd0);
        chk("E.rstpulse", 32'(pulse_out), 32'd0);
        chk("E.rststep", 32'(step_idx), 32'd0);
        chk("E.rstdone", 32'(done), 32'd0);
        tick();
        HRESET = 1'b0;
        for (int s = 0; s < DEPTH; s++)
            for (int c = 0; c < NUM_CH; c++) tbl[s][c] = 0;
        tick();
        begin_run(2);
        play("E2", 40, 0, 0, CH_TRIP, cnt);
        chk("E2.count", 32'(cnt), 32'd0);
        expect_end("E2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
